fec_cc_encoder: RTL and testbench

- Rate-1/2 tail-biting convolutional encoder. Sits directly downstream of the PRBS randomizer and consumes its serial randomized bit stream in 96-bit blocks.
- Each block produces 192 coded bits serially toward the interleaver.
- Uses a ping-pong buffer. One 96-bit block can be captured while the previous block is encoded, because tail-biting needs the last 6 bits of a block before encoding starts.

---
 rtl/fec_cc_encoder_if.sv | 41 ++++
 rtl/fec_cc_encoder.sv | 193 +++++++++++++++++++
 tb/tb_fec_cc_encoder.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fec_cc_encoder_if.sv
// ---------------------------------------------------------------------------
// fec_cc_encoder_if
//   Groups the serial streams around the convolutional encoder.
//   Upstream side (from the randomizer): data_in, valid_in, ready_out.
//   Downstream side (to the interleaver): data_out, valid_out, sop_out,
//   eop_out, ready_in.
//   slave  : the encoder's view (consumes data_in, produces data_out).
//   master : the surrounding logic's view (drives data_in and ready_in).
// ---------------------------------------------------------------------------
interface fec_cc_encoder_if;
  logic data_in;
  logic valid_in;
  logic ready_out;
  logic data_out;
  logic valid_out;
  logic sop_out;
  logic eop_out;
  logic ready_in;

  modport slave (
    input  data_in,
    input  valid_in,
    input  ready_in,
    output ready_out,
    output data_out,
    output valid_out,
    output sop_out,
    output eop_out
  );

  modport master (
    output data_in,
    output valid_in,
    output ready_in,
    input  ready_out,
    input  data_out,
    input  valid_out,
    input  sop_out,
    input  eop_out
  );
endinterface

// File: rtl/fec_cc_encoder.sv
// ---------------------------------------------------------------------------
// fec_cc_encoder
//   Rate-1/2, constraint-length-7 tail-biting convolutional encoder
//   (G1 = 171 octal, G2 = 133 octal). Serial randomized bits are captured
//   into one half of a two-bank ping-pong buffer while the other half is
//   encoded. Tail-biting needs the last six bits of a block before the first
//   output, so a block is only encoded once it has been fully captured.
//   Output order per block: X0, Y0, X1, Y1, ... X95, Y95.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   bus.data_in / bus.valid_in / bus.ready_out   upstream serial stream
//   bus.data_out / bus.valid_out / bus.ready_in  downstream coded stream
//   bus.sop_out  marks X0, bus.eop_out marks Y95
// ---------------------------------------------------------------------------
module fec_cc_encoder #(
  parameter int BLOCK_BITS = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  fec_cc_encoder_if.slave  bus
);

  localparam int MEM   = 6;
  localparam int CNT_W = $clog2(BLOCK_BITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_BITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ENCODE} state_e;

  logic [BLOCK_BITS-1:0] bank_q [2];
  logic [BLOCK_BITS-1:0] bank_d [2];
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;

  state_e                state_q, state_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [MEM:1]          s_q, s_d;
  logic [CNT_W-1:0]      n_q, n_d;
  logic                  phase_q, phase_d;

  logic                  data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;

  logic                  ready_out;
  logic                  accept;
  logic                  advance;
  logic                  cur_bit;
  logic                  blk_release;

  // s[k] holds u_{n-k}; the generators tap the current bit plus the memory.
  function automatic logic g1(input logic u, input logic [MEM:1] s);
    return u ^ s[1] ^ s[2] ^ s[3] ^ s[6];
  endfunction

  function automatic logic g2(input logic u, input logic [MEM:1] s);
    return u ^ s[2] ^ s[3] ^ s[5] ^ s[6];
  endfunction

  // ready_out depends only on registered flags so no path exists from the
  // downstream ready back to the upstream ready.
  assign ready_out   = !full_q[wr_bank_q];
  assign accept      = bus.valid_in && ready_out;
  assign advance     = valid_out_q && bus.ready_in;
  assign cur_bit     = bank_q[rd_bank_q][n_q];
  assign blk_release = (state_q == ENCODE) && advance && phase_q && (n_q == LAST);

  assign bus.ready_out = ready_out;
  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.sop_out   = sop_q;
  assign bus.eop_out   = eop_q;

  // Write side: store accepted bits and hand a bank over once it is complete.
  // Release and completion always hit different banks, because a full bank
  // blocks the writer until the reader releases it.
  always_comb begin
    bank_d    = bank_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    if (blk_release) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (accept) begin
      bank_d[wr_bank_q][wr_cnt_q] = bus.data_in;
      if (wr_cnt_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end
  end

  // Read side: the output registers always hold the coded bit for the current
  // (n, phase), so each advance precomputes the next bit to present.
  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    s_d         = s_q;
    n_d         = n_q;
    phase_d     = phase_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Tail-biting: the memory starts with the block's own last bits.
        for (int k = 1; k <= MEM; k++) begin
          s_d[k] = bank_q[rd_bank_q][BLOCK_BITS-k];
        end
        n_d         = '0;
        phase_d     = 1'b0;
        data_out_d  = g1(bank_q[rd_bank_q][0], s_d);
        valid_out_d = 1'b1;
        sop_d       = 1'b1;
        eop_d       = 1'b0;
        state_d     = ENCODE;
      end
      ENCODE: begin
        if (advance) begin
          if (!phase_q) begin
            phase_d    = 1'b1;
            data_out_d = g2(cur_bit, s_q);
            sop_d      = 1'b0;
            eop_d      = (n_q == LAST);
          end else if (n_q == LAST) begin
            rd_bank_d   = ~rd_bank_q;
            phase_d     = 1'b0;
            data_out_d  = 1'b0;
            valid_out_d = 1'b0;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
            state_d     = full_q[~rd_bank_q] ? LOAD : IDLE;
          end else begin
            s_d        = {s_q[MEM-1:1], cur_bit};
            n_d        = n_q + CNT_W'(1);
            phase_d    = 1'b0;
            data_out_d = g1(bank_q[rd_bank_q][n_d], s_d);
            sop_d      = 1'b0;
            eop_d      = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state registers; reset discards any buffered or partially sent block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q      <= '{default: '0};
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      state_q     <= IDLE;
      rd_bank_q   <= 1'b0;
      s_q         <= '0;
      n_q         <= '0;
      phase_q     <= 1'b0;
      data_out_q  <= 1'b0;
      valid_out_q <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      s_q         <= s_d;
      n_q         <= n_d;
      phase_q     <= phase_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
    end
  end

endmodule

// File: tb/tb_fec_cc_encoder.sv
// ---------------------------------------------------------------------------
// tb_fec_cc_encoder
//   Self-checking bench for fec_cc_encoder. Every accepted input bit is
//   collected into a 96-bit block; a complete block is expanded into its 192
//   expected coded bits with modular (circular) indexing, and the monitor
//   compares each downstream transfer against that expectation. Literal
//   impulse-response patterns pin the expected stream for single-bit blocks.
// ---------------------------------------------------------------------------
module tb_fec_cc_encoder;

  localparam int BB = 96;

  logic clk = 1'b0;
  logic rst_n;

  fec_cc_encoder_if bus ();

  fec_cc_encoder #(.BLOCK_BITS(BB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Counters and monitor-owned bookkeeping
  int             compared = 0;
  int             mismatched = 0;
  logic [2:0]     exp_q [$];
  logic [BB-1:0]  in_blk;
  int             in_cnt = 0;
  logic [2*BB-1:0] cap;
  int             cap_idx = 0;
  bit             hold_pending = 0;
  logic [2:0]     hold_val;
  bit             after_eop = 0;
  int             gap_cnt = 0;
  int             gap_q [$];
  int             stall_in_cnt = 0;
  bit             lat_pending = 0;
  int             lat_k = 0;
  bit             rst_seen = 0;

  // Requests written only by the stimulus process
  logic [2*BB-1:0] lit_vec = '0;
  bit             lit_active = 0;
  bit             rand_ready = 0;
  bit             chk_drain = 0;
  bit             t4_start = 0;
  bit             chk_t4 = 0;

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: X_n and Y_n from the generator taps with indices taken
  // modulo the block length, which is exactly the tail-biting definition.
  task automatic buildExpected(input logic [BB-1:0] u);
    logic x, y;
    for (int n = 0; n < BB; n++) begin
      x = u[n] ^ u[(n+BB-1)%BB] ^ u[(n+BB-2)%BB] ^ u[(n+BB-3)%BB] ^ u[(n+BB-6)%BB];
      y = u[n] ^ u[(n+BB-2)%BB] ^ u[(n+BB-3)%BB] ^ u[(n+BB-5)%BB] ^ u[(n+BB-6)%BB];
      exp_q.push_back({x, (n == 0), 1'b0});
      exp_q.push_back({y, 1'b0, (n == BB-1)});
    end
  endtask

  // Downstream ready: constant 1, or a fair coin when stalls are requested.
  initial begin
    bus.ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples on the falling edge, i.e. the values the next rising
  // edge will act upon.
  always @(negedge clk) begin
    logic [2:0] got;
    logic [2:0] want;
    if (!rst_n) begin
      checkOutput("reset_outputs",
                  {bus.valid_out, bus.data_out, bus.sop_out, bus.eop_out, bus.ready_out}, 5'b00001);
      exp_q.delete();
      in_cnt = 0;
      cap_idx = 0;
      hold_pending = 0;
      after_eop = 0;
      gap_cnt = 0;
      lat_pending = 0;
      rst_seen = 1;
    end else begin
      if (rst_seen) begin
        checkOutput("post_reset_outputs",
                    {bus.valid_out, bus.data_out, bus.sop_out, bus.eop_out, bus.ready_out}, 5'b00001);
        rst_seen = 0;
      end
      if (t4_start) begin
        gap_q.delete();
        stall_in_cnt = 0;
      end
      if (lat_pending) begin
        lat_k++;
        if (lat_k == 2) begin
          checkOutput("latency_load_cycle_idle", bus.valid_out, 1'b0);
        end else if (lat_k == 3) begin
          checkOutput("latency_x0_valid_sop", {bus.valid_out, bus.sop_out}, 2'b11);
          lat_pending = 0;
        end
      end
      if (hold_pending) begin
        checkOutput("stall_hold", {bus.valid_out, bus.data_out, bus.sop_out, bus.eop_out},
                    {1'b1, hold_val});
        hold_pending = 0;
      end
      if (bus.valid_out && !bus.ready_in) begin
        hold_val = {bus.data_out, bus.sop_out, bus.eop_out};
        hold_pending = 1;
      end
      if (bus.valid_out && bus.ready_in) begin
        got = {bus.data_out, bus.sop_out, bus.eop_out};
        if (exp_q.size() == 0) begin
          checkOutput("output_without_block", exp_q.size(), 1);
        end else begin
          want = exp_q.pop_front();
          checkOutput("coded_stream", got, want);
        end
        if (cap_idx < 2*BB) cap[cap_idx] = bus.data_out;
        cap_idx++;
        if (bus.sop_out && after_eop) begin
          gap_q.push_back(gap_cnt);
          after_eop = 0;
        end
        if (bus.eop_out) begin
          if (lit_active) checkOutput("literal_block", cap, lit_vec);
          cap_idx = 0;
          after_eop = 1;
          gap_cnt = 0;
        end
      end else if (!bus.valid_out && after_eop) begin
        gap_cnt++;
      end
      if (bus.valid_in && bus.ready_out) begin
        in_blk[in_cnt] = bus.data_in;
        in_cnt++;
        if (in_cnt == BB) begin
          if (exp_q.size() == 0 && !bus.valid_out) begin
            lat_pending = 1;
            lat_k = 0;
          end
          buildExpected(in_blk);
          in_cnt = 0;
        end
      end
      if (bus.valid_in && !bus.ready_out) stall_in_cnt++;
      if (chk_t4) begin
        checkOutput("input_throttled", (stall_in_cnt > 0), 1'b1);
        checkOutput("block_start_count", gap_q.size(), 3);
        if (gap_q.size() >= 3) begin
          checkOutput("b2b_gap_block2", gap_q[1], 1);
          checkOutput("b2b_gap_block3", gap_q[2], 1);
        end
      end
      if (chk_drain) begin
        checkOutput("drained_queue_and_input", {exp_q.size(), in_cnt}, 0);
      end
    end
  end

  // Drives one bit and returns after the rising edge that accepts it.
  task automatic sendBit(input logic b);
    bus.data_in  = b;
    bus.valid_in = 1'b1;
    for (int g = 0; g < 3000; g++) begin
      @(negedge clk);
      if (bus.ready_out) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [BB-1:0] blk, input bit keep_valid);
    for (int n = 0; n < BB; n++) sendBit(blk[n]);
    if (!keep_valid) bus.valid_in = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && in_cnt == 0 && !bus.valid_out) break;
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulseDrain();
    chk_drain = 1;
    @(posedge clk);
    #1;
    chk_drain = 0;
  endtask

  // Hand-derived impulse responses (coded index 2n = X_n, 2n+1 = Y_n).
  task automatic setLitFirstBit();
    int xs[5] = '{0, 1, 2, 3, 6};
    int ys[5] = '{0, 2, 3, 5, 6};
    lit_vec = '0;
    foreach (xs[i]) lit_vec[2*xs[i]] = 1'b1;
    foreach (ys[i]) lit_vec[2*ys[i]+1] = 1'b1;
  endtask

  task automatic setLitLastBit();
    int xs[5] = '{95, 0, 1, 2, 5};
    int ys[5] = '{95, 1, 2, 4, 5};
    lit_vec = '0;
    foreach (xs[i]) lit_vec[2*xs[i]] = 1'b1;
    foreach (ys[i]) lit_vec[2*ys[i]+1] = 1'b1;
  endtask

  function automatic logic [BB-1:0] randBlock();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [BB-1:0] blk;
    rst_n        = 1'b0;
    bus.data_in  = 1'b0;
    bus.valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] all-zero block");
    lit_active = 1;
    lit_vec = '0;
    applyStimulus('0, 0);
    waitDrain(800);
    pulseDrain();

    $display("[TB] impulse at u0");
    setLitFirstBit();
    blk = '0;
    blk[0] = 1'b1;
    applyStimulus(blk, 0);
    waitDrain(800);
    pulseDrain();

    $display("[TB] impulse at u95 (wrap)");
    setLitLastBit();
    blk = '0;
    blk[BB-1] = 1'b1;
    applyStimulus(blk, 0);
    waitDrain(800);
    pulseDrain();
    lit_active = 0;

    $display("[TB] three back-to-back random blocks");
    t4_start = 1;
    @(posedge clk);
    #1;
    t4_start = 0;
    for (int b = 0; b < 3; b++) applyStimulus(randBlock(), 1);
    bus.valid_in = 1'b0;
    waitDrain(2000);
    chk_t4 = 1;
    @(posedge clk);
    #1;
    chk_t4 = 0;
    pulseDrain();

    $display("[TB] random downstream stalls");
    rand_ready = 1;
    for (int b = 0; b < 2; b++) applyStimulus(randBlock(), 0);
    waitDrain(3000);
    rand_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    pulseDrain();

    $display("[TB] reset during encode");
    applyStimulus(randBlock(), 0);
    for (int i = 0; i < 1000 && cap_idx < 80; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lit_active = 1;
    setLitFirstBit();
    blk = '0;
    blk[0] = 1'b1;
    applyStimulus(blk, 0);
    waitDrain(800);
    pulseDrain();
    lit_active = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
